// File: rtl/wires.sv
`default_nettype none
// ============================================================================
// Package : wires
// Brief   : Core memory bus request/response types and the dram_ui FSM states.
// Rev     : 1.0  initial release
// ============================================================================
package wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
  } mem_out_type;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAITCAL = 3'd1,
    ERROR   = 3'd2,
    WRDATA  = 3'd3,
    WRCMD   = 3'd4,
    RDCMD   = 3'd5,
    RDDATA  = 3'd6,
    RESP    = 3'd7
  } dram_ui_state_t;

  localparam logic [2:0] c_app_cmd_write = 3'b000;
  localparam logic [2:0] c_app_cmd_read  = 3'b001;

endpackage
`default_nettype wire

// File: rtl/dram_line_buf.sv
`default_nettype none
// ============================================================================
// Module : dram_line_buf
// Brief  : Single-line read buffer (tag, data, valid) with write-through merge.
// Rev    : 1.0  initial release
// ============================================================================
module dram_line_buf #(
  parameter int LINE_WIDTH = 128,
  parameter int TAG_WIDTH  = 23
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    calib_complete,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    hit,
  output logic [LINE_WIDTH-1:0]   line_data,
  input  logic                    fill_en,
  input  logic [LINE_WIDTH-1:0]   fill_data,
  input  logic                    wr_en,
  input  logic [LINE_WIDTH-1:0]   wr_data,
  input  logic [LINE_WIDTH/8-1:0] wr_mask
);

  logic                  r_valid;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [LINE_WIDTH-1:0] r_data;
  logic [LINE_WIDTH-1:0] w_merged;

  assign hit       = r_valid && (r_tag == req_tag);
  assign line_data = r_data;

  // Mask bit set means the byte is not written, matching the MIG convention.
  for (genvar i = 0; i < LINE_WIDTH / 8; i++) begin : g_bytes
    assign w_merged[8*i +: 8] = wr_mask[i] ? r_data[8*i +: 8] : wr_data[8*i +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      if (fill_en) begin
        r_valid <= 1'b1;
        r_tag   <= req_tag;
        r_data  <= fill_data;
      end else if (wr_en && hit) begin
        r_data  <= w_merged;
      end
      if (!calib_complete) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_ui.sv
`default_nettype none
// ============================================================================
// Module : dram_ui
// Brief  : Core memory bus to MIG user-interface adapter (ui_clk domain).
//          Optional one-line read buffer enabled by DRAM_LINE_BUF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module dram_ui
  import wires::*;
#(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 27,
  parameter int MEM_SIZE_LOG2  = 27
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        calib_complete,
  input  mem_in_type                  dram_in,
  output mem_out_type                 dram_out,
  output logic [APP_ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  input  logic                        app_rd_data_valid
);

  localparam int c_words  = APP_DATA_WIDTH / 32;
  localparam int c_offset = $clog2(APP_DATA_WIDTH / 8);
  localparam int c_sel_w  = c_offset - 2;
  localparam int c_mask_w = APP_DATA_WIDTH / 8;

  dram_ui_state_t r_state, w_state_next;
  mem_in_type     r_req, w_req;

  logic [APP_ADDR_WIDTH-1:0] r_app_addr, w_app_addr_next, w_line_addr;
  logic [2:0]                r_app_cmd, w_app_cmd_next;
  logic                      r_app_en, w_app_en_next;
  logic [APP_DATA_WIDTH-1:0] r_wdf_data, w_wdf_data_next, w_wr_data;
  logic [c_mask_w-1:0]       r_wdf_mask, w_wdf_mask_next, w_wr_mask;
  logic                      r_wdf_wren, w_wdf_wren_next;
  logic [31:0]               r_rdata, w_rdata_next;
  logic                      r_ready, w_ready_next;
  logic                      r_error, w_error_next;

  logic                      w_dispatch;
  logic                      w_out_of_range;
  logic [c_sel_w-1:0]        w_sel;
  logic [APP_DATA_WIDTH-1:0] w_src_line;
  logic [31:0]               w_words [c_words];
  logic                      w_buf_hit, w_buf_fill, w_buf_wr;
  logic [APP_DATA_WIDTH-1:0] w_buf_line;
  logic                      w_unused;

  // In IDLE the live request drives the decode so outputs are ready one cycle later.
  assign w_req          = (r_state == IDLE) ? dram_in : r_req;
  assign w_sel          = w_req.mem_addr[c_offset-1:2];
  assign w_out_of_range = (w_req.mem_addr >> MEM_SIZE_LOG2) != 32'd0;
  assign w_line_addr    = {w_req.mem_addr[APP_ADDR_WIDTH-1:c_offset], {c_offset{1'b0}}};
  assign w_wr_data      = {c_words{w_req.mem_wdata}};
  assign w_src_line     = (r_state == RDDATA) ? app_rd_data : w_buf_line;
  assign w_unused       = ^{w_req.mem_valid, w_req.mem_instr, w_req.mem_mode,
                            w_req.mem_addr[1:0]};

  for (genvar i = 0; i < c_words; i++) begin : g_words
    assign w_words[i]          = w_src_line[32*i +: 32];
    assign w_wr_mask[4*i +: 4] = (w_sel == c_sel_w'(i)) ? ~w_req.mem_wstrb : 4'hF;
  end

`ifdef DRAM_LINE_BUF_EN
  dram_line_buf #(
    .LINE_WIDTH (APP_DATA_WIDTH),
    .TAG_WIDTH  (MEM_SIZE_LOG2 - c_offset)
  ) u_line_buf (
    .clock          (clock),
    .reset          (reset),
    .calib_complete (calib_complete),
    .req_tag        (w_req.mem_addr[MEM_SIZE_LOG2-1:c_offset]),
    .hit            (w_buf_hit),
    .line_data      (w_buf_line),
    .fill_en        (w_buf_fill),
    .fill_data      (app_rd_data),
    .wr_en          (w_buf_wr),
    .wr_data        (w_wr_data),
    .wr_mask        (w_wr_mask)
  );
`else
  logic w_unused_buf;
  assign w_buf_hit    = 1'b0;
  assign w_buf_line   = '0;
  assign w_unused_buf = w_buf_fill | w_buf_wr;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_app_addr_next = r_app_addr;
    w_app_cmd_next  = r_app_cmd;
    w_app_en_next   = 1'b0;
    w_wdf_data_next = r_wdf_data;
    w_wdf_mask_next = r_wdf_mask;
    w_wdf_wren_next = 1'b0;
    w_rdata_next    = '0;
    w_ready_next    = 1'b0;
    w_error_next    = 1'b0;
    w_dispatch      = 1'b0;
    w_buf_fill      = 1'b0;
    w_buf_wr        = 1'b0;

    case (r_state)
      IDLE: begin
        if (dram_in.mem_valid) begin
          if (w_out_of_range) begin
            w_state_next = ERROR;
            w_ready_next = 1'b1;
            w_error_next = 1'b1;
          end else if (!calib_complete) begin
            w_state_next = WAITCAL;
          end else begin
            w_dispatch = 1'b1;
          end
        end
      end
      WAITCAL: w_dispatch = calib_complete;
      ERROR, RESP: w_state_next = IDLE;
      WRDATA: begin
        if (app_wdf_rdy) begin
          w_state_next   = WRCMD;
          w_app_en_next  = 1'b1;
          w_app_cmd_next = c_app_cmd_write;
        end else begin
          w_wdf_wren_next = 1'b1;
        end
      end
      WRCMD: begin
        if (app_rdy) begin
          w_state_next = RESP;
          w_ready_next = 1'b1;
        end else begin
          w_app_en_next = 1'b1;
        end
      end
      RDCMD: begin
        if (app_rdy) w_state_next  = RDDATA;
        else         w_app_en_next = 1'b1;
      end
      RDDATA: begin
        if (app_rd_data_valid) begin
          w_state_next = RESP;
          w_ready_next = 1'b1;
          w_rdata_next = w_words[w_sel];
          w_buf_fill   = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_dispatch) begin
      w_app_addr_next = w_line_addr;
      if (w_req.mem_wstrb != 4'd0) begin
        w_state_next    = WRDATA;
        w_wdf_wren_next = 1'b1;
        w_wdf_data_next = w_wr_data;
        w_wdf_mask_next = w_wr_mask;
        w_buf_wr        = 1'b1;
      end else if (w_buf_hit) begin
        w_state_next = RESP;
        w_ready_next = 1'b1;
        w_rdata_next = w_words[w_sel];
      end else begin
        w_state_next   = RDCMD;
        w_app_en_next  = 1'b1;
        w_app_cmd_next = c_app_cmd_read;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_app_addr <= '0;
      r_app_cmd  <= '0;
      r_app_en   <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
      r_wdf_wren <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      if (r_state == IDLE && dram_in.mem_valid) begin
        r_req <= dram_in;
      end
      r_app_addr <= w_app_addr_next;
      r_app_cmd  <= w_app_cmd_next;
      r_app_en   <= w_app_en_next;
      r_wdf_data <= w_wdf_data_next;
      r_wdf_mask <= w_wdf_mask_next;
      r_wdf_wren <= w_wdf_wren_next;
      r_rdata    <= w_rdata_next;
      r_ready    <= w_ready_next;
      r_error    <= w_error_next;
    end
  end

  assign app_addr           = r_app_addr;
  assign app_cmd            = r_app_cmd;
  assign app_en             = r_app_en;
  assign app_wdf_data       = r_wdf_data;
  assign app_wdf_mask       = r_wdf_mask;
  assign app_wdf_wren       = r_wdf_wren;
  assign app_wdf_end        = r_wdf_wren;
  assign dram_out.mem_rdata = r_rdata;
  assign dram_out.mem_ready = r_ready;
  assign dram_out.mem_error = r_error;

endmodule
`default_nettype wire
